burst_rd: RTL and testbench



---
 rtl/burst_rd_pkg.sv | 20 ++
 rtl/burst_rd_if.sv | 28 ++
 rtl/burst_rd_pipe.sv | 44 ++++
 rtl/burst_rd.sv | 113 +++++++++++
 tb/tb_burst_rd.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/burst_rd_pkg.sv
// Shared definitions for the chip-select burst initiators: phase encoding and
// parameter sanity checks.
package burst_rd_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StCs0  = 3'd1,
    StData = 3'd2,
    StCs1  = 3'd3,
    StRedy = 3'd4
  } state_e;

  // Counter must reach LEN-1 and GAP; read data must land before the hold gap ends.
  function automatic bit params_ok(int unsigned aw, int unsigned len, int unsigned gap,
                                   int unsigned rlat);
    return (len >= 1) && ((64'd1 << aw) >= 64'(len)) && ((64'd1 << aw) > 64'(gap)) &&
           (rlat >= 1) && (rlat <= gap);
  endfunction

endpackage

// File: rtl/burst_rd_if.sv
// Request/ack handshake, SRAM-style target strobes and the captured read stream.
interface burst_rd_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 8
) ();

  logic          req;
  logic          ack;
  logic [AW-1:0] st;
  logic          csn;
  logic          oe;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic [AW-1:0] dout_idx;

  modport master (
    input  req, rdata,
    output ack, st, csn, oe, addr, dout, dout_vld, dout_idx
  );

  modport slave (
    output req, rdata,
    input  ack, st, csn, oe, addr, dout, dout_vld, dout_idx
  );

endinterface

// File: rtl/burst_rd_pipe.sv
// Delays each read strobe's {valid, addr} by the target latency, then captures
// rdata alongside the address that produced it.
module burst_rd_pipe #(
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 8,
  parameter int unsigned RLAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          oe,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic [AW-1:0] dout_idx
);

  logic [RLAT-1:0] vld_sr;
  logic [AW-1:0]   idx_sr [RLAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr   <= '0;
      for (int i = 0; i < RLAT; i++) idx_sr[i] <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_idx <= '0;
    end else begin
      vld_sr[0] <= oe;
      idx_sr[0] <= addr;
      for (int i = 1; i < RLAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        idx_sr[i] <= idx_sr[i-1];
      end
      // Last stage lines up with the cycle in which the target drives rdata.
      dout_vld <= vld_sr[RLAT-1];
      if (vld_sr[RLAT-1]) begin
        dout     <= rdata;
        dout_idx <= idx_sr[RLAT-1];
      end
    end
  end

endmodule

// File: rtl/burst_rd.sv
// Burst-read initiator: on a synchronised request, select the target, sweep
// addr 0..LEN-1 with a read strobe, stream the returned words, then acknowledge.
module burst_rd
  import burst_rd_pkg::*;
#(
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 8,
  parameter int unsigned GAP  = 3,
  parameter int unsigned LEN  = 20,
  parameter int unsigned RLAT = 1
) (
  input logic        clk,
  input logic        rst,
  burst_rd_if.master bus
);

  if (!params_ok(AW, LEN, GAP, RLAT)) begin : g_bad_params
    $error("burst_rd: illegal AW/LEN/GAP/RLAT combination");
  end

  localparam logic [AW-1:0] GapCnt  = AW'(GAP);
  localparam logic [AW-1:0] LastCnt = AW'(LEN - 1);

  state_e        state_q;
  logic [1:0]    req_sync;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] addr_q;
  logic          csn_q, oe_q, ack_q;
  logic          req_s, gap, last;

  assign req_s = req_sync[1];
  assign gap   = (cnt_q >= GapCnt);
  assign last  = (cnt_q >= LastCnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_sync <= 2'b00;
      state_q  <= StIdle;
      cnt_q    <= '0;
      csn_q    <= 1'b1;
      oe_q     <= 1'b0;
      addr_q   <= '0;
      ack_q    <= 1'b0;
    end else begin
      req_sync <= {req_sync[0], bus.req};
      csn_q    <= !(state_q inside {StCs0, StData, StCs1});
      oe_q     <= (state_q == StData);
      ack_q    <= (state_q == StRedy);
      if (state_q == StData) addr_q <= cnt_q;

      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (req_s) state_q <= StCs0;
        end
        StCs0: begin
          if (gap) begin
            cnt_q   <= '0;
            state_q <= StData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (last) begin
            cnt_q   <= '0;
            state_q <= StCs1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StCs1: begin
          if (gap) begin
            cnt_q   <= '0;
            state_q <= StRedy;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRedy: begin
          cnt_q <= '0;
          if (!req_s) state_q <= StIdle;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.csn  = csn_q;
  assign bus.oe   = oe_q;
  assign bus.addr = addr_q;
  assign bus.ack  = ack_q;
  assign bus.st   = cnt_q;

  burst_rd_pipe #(
    .AW  (AW),
    .DW  (DW),
    .RLAT(RLAT)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .oe      (oe_q),
    .addr    (addr_q),
    .rdata   (bus.rdata),
    .dout    (bus.dout),
    .dout_vld(bus.dout_vld),
    .dout_idx(bus.dout_idx)
  );

endmodule

// File: tb/tb_burst_rd.sv
// Directed bench for burst_rd: two instances (read latency 1 and 3) driven by
// the same request, each attached to a latency-matched target model.
module tb_burst_rd;
  import burst_rd_pkg::*;

  logic clk;
  logic rst;
  logic req;
  int   tests;
  int   fails;

  burst_rd_if #(.AW(5), .DW(8)) if1 ();
  burst_rd_if #(.AW(5), .DW(8)) if3 ();

  assign if1.req = req;
  assign if3.req = req;

  burst_rd #(.AW(5), .DW(8), .GAP(3), .LEN(20), .RLAT(1)) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(if1.master)
  );

  burst_rd #(.AW(5), .DW(8), .GAP(3), .LEN(20), .RLAT(3)) dut3 (
    .clk(clk),
    .rst(rst),
    .bus(if3.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Targets return 8'hA0 + addr, RLAT cycles after the strobe is seen.
  logic       t1_v;
  logic [4:0] t1_a;
  logic [2:0] t3_v;
  logic [4:0] t3_a0, t3_a1, t3_a2;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t1_v <= 1'b0;
      t1_a <= '0;
      t3_v <= '0;
      t3_a0 <= '0;
      t3_a1 <= '0;
      t3_a2 <= '0;
    end else begin
      t1_v  <= if1.oe;
      t1_a  <= if1.addr;
      t3_v  <= {t3_v[1:0], if3.oe};
      t3_a0 <= if3.addr;
      t3_a1 <= t3_a0;
      t3_a2 <= t3_a1;
    end
  end

  assign if1.rdata = t1_v    ? 8'(8'hA0 + {3'b000, t1_a}) : 8'h00;
  assign if3.rdata = t3_v[2] ? 8'(8'hA0 + {3'b000, t3_a2}) : 8'h00;

  task automatic test_reset();
    rst = 1'b1;
    req = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (if1.csn !== 1'b1 || if1.oe !== 1'b0 || if1.addr !== 5'd0 || if1.ack !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl got csn=%b oe=%b addr=%0d ack=%b exp 1 0 0 0",
               if1.csn, if1.oe, if1.addr, if1.ack);
    end
    tests++;
    if (if1.dout !== 8'h00 || if1.dout_vld !== 1'b0 || if1.dout_idx !== 5'd0 ||
        if1.st !== 5'd0) begin
      fails++;
      $display("FAIL reset_data got dout=%h vld=%b idx=%0d st=%0d exp 00 0 0 0",
               if1.dout, if1.dout_vld, if1.dout_idx, if1.st);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (if1.csn !== 1'b1 || if3.csn !== 1'b1) begin
      fails++;
      $display("FAIL idle_csn got %b/%b exp 1/1", if1.csn, if3.csn);
    end
  endtask

  task automatic test_burst();
    logic       e_csn, e_oe, e_ack, e_v1, e_v3;
    logic [4:0] e_addr, e_st, e_i1, e_i3;
    logic [7:0] e_d1, e_d3;
    req = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      e_csn  = !(cyc >= 4 && cyc <= 31);
      e_oe   = (cyc >= 8 && cyc <= 27);
      e_addr = (cyc < 8) ? 5'd0 : (cyc <= 27) ? 5'(cyc - 8) : 5'd19;
      e_st   = (cyc >= 3 && cyc <= 6) ? 5'(cyc - 3) : (cyc >= 7 && cyc <= 26) ? 5'(cyc - 7) :
               (cyc >= 27 && cyc <= 30) ? 5'(cyc - 27) : 5'd0;
      e_ack  = (cyc >= 32);
      e_v1   = (cyc >= 10 && cyc <= 29);
      e_i1   = (cyc < 10) ? 5'd0 : (cyc <= 29) ? 5'(cyc - 10) : 5'd19;
      e_d1   = (cyc < 10) ? 8'h00 : 8'(8'hA0 + e_i1);
      e_v3   = (cyc >= 12 && cyc <= 31);
      e_i3   = (cyc < 12) ? 5'd0 : (cyc <= 31) ? 5'(cyc - 12) : 5'd19;
      e_d3   = (cyc < 12) ? 8'h00 : 8'(8'hA0 + e_i3);
      tests++;
      if (if1.csn !== e_csn || if1.oe !== e_oe || if1.addr !== e_addr) begin
        fails++;
        $display("FAIL burst_strobe cyc=%0d got csn=%b oe=%b addr=%0d exp %b %b %0d",
                 cyc, if1.csn, if1.oe, if1.addr, e_csn, e_oe, e_addr);
      end
      tests++;
      if (if1.st !== e_st || if1.ack !== e_ack || if3.ack !== e_ack) begin
        fails++;
        $display("FAIL burst_st_ack cyc=%0d got st=%0d ack=%b/%b exp %0d %b",
                 cyc, if1.st, if1.ack, if3.ack, e_st, e_ack);
      end
      tests++;
      if (if1.dout_vld !== e_v1 || if1.dout_idx !== e_i1 || if1.dout !== e_d1) begin
        fails++;
        $display("FAIL rlat1_data cyc=%0d got vld=%b idx=%0d dout=%h exp %b %0d %h",
                 cyc, if1.dout_vld, if1.dout_idx, if1.dout, e_v1, e_i1, e_d1);
      end
      tests++;
      if (if3.dout_vld !== e_v3 || if3.dout_idx !== e_i3 || if3.dout !== e_d3) begin
        fails++;
        $display("FAIL rlat3_data cyc=%0d got vld=%b idx=%0d dout=%h exp %b %0d %h",
                 cyc, if3.dout_vld, if3.dout_idx, if3.dout, e_v3, e_i3, e_d3);
      end
      tests++;
      if (if3.dout_vld === 1'b1 && if3.ack === 1'b1) begin
        fails++;
        $display("FAIL rlat3_overlap cyc=%0d got vld&ack=1 exp 0", cyc);
      end
    end
    req = 1'b0;
    repeat (6) @(negedge clk);
    tests++;
    if (if1.ack !== 1'b0 || if3.ack !== 1'b0 || if1.csn !== 1'b1) begin
      fails++;
      $display("FAIL burst_release got ack=%b/%b csn=%b exp 0/0 1", if1.ack, if3.ack, if1.csn);
    end
  endtask

  task automatic test_req_drop();
    int   words = 0;
    logic e_ack;
    req = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (if1.dout_vld === 1'b1) begin
        tests++;
        if (if1.dout_idx !== 5'(words) || if1.dout !== 8'(8'hA0 + words)) begin
          fails++;
          $display("FAIL drop_word cyc=%0d got idx=%0d dout=%h exp %0d %h",
                   cyc, if1.dout_idx, if1.dout, words, 8'(8'hA0 + words));
        end
        words++;
      end
      e_ack = (cyc == 32);
      tests++;
      if (if1.ack !== e_ack) begin
        fails++;
        $display("FAIL drop_ack cyc=%0d got %b exp %b", cyc, if1.ack, e_ack);
      end
      if (cyc >= 32) begin
        tests++;
        if (if1.csn !== 1'b1 || if1.oe !== 1'b0) begin
          fails++;
          $display("FAIL drop_rerun cyc=%0d got csn=%b oe=%b exp 1 0", cyc, if1.csn, if1.oe);
        end
      end
      if (cyc == 15) req = 1'b0;
    end
    tests++;
    if (words != 20) begin
      fails++;
      $display("FAIL drop_count got %0d exp 20", words);
    end
  endtask

  task automatic test_reset_mid();
    logic       e_csn, e_oe, e_v;
    logic [4:0] e_addr;
    req = 1'b1;
    repeat (15) @(negedge clk);
    tests++;
    if (if1.addr !== 5'd7 || if1.oe !== 1'b1) begin
      fails++;
      $display("FAIL mid_pre got addr=%0d oe=%b exp 7 1", if1.addr, if1.oe);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (if1.csn !== 1'b1 || if1.oe !== 1'b0 || if1.dout_vld !== 1'b0 || if1.ack !== 1'b0 ||
        if1.addr !== 5'd0 || if3.csn !== 1'b1) begin
      fails++;
      $display("FAIL mid_async got csn=%b oe=%b vld=%b ack=%b addr=%0d exp 1 0 0 0 0",
               if1.csn, if1.oe, if1.dout_vld, if1.ack, if1.addr);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      e_csn  = (cyc < 4);
      e_oe   = (cyc >= 8);
      e_addr = (cyc >= 8) ? 5'(cyc - 8) : 5'd0;
      e_v    = (cyc >= 10);
      tests++;
      if (if1.csn !== e_csn || if1.oe !== e_oe || if1.addr !== e_addr ||
          if1.dout_vld !== e_v) begin
        fails++;
        $display("FAIL mid_restart cyc=%0d got csn=%b oe=%b addr=%0d vld=%b exp %b %b %0d %b",
                 cyc, if1.csn, if1.oe, if1.addr, if1.dout_vld, e_csn, e_oe, e_addr, e_v);
      end
    end
    req = 1'b0;
    repeat (45) @(negedge clk);
    tests++;
    if (if1.ack !== 1'b0 || if1.csn !== 1'b1 || if1.st !== 5'd0) begin
      fails++;
      $display("FAIL mid_drain got ack=%b csn=%b st=%0d exp 0 1 0", if1.ack, if1.csn, if1.st);
    end
  endtask

  task automatic test_bad_state();
    for (int code = 5; code <= 7; code++) begin
      @(negedge clk);
      force dut1.state_q = state_e'(3'(code));
      #1;
      release dut1.state_q;
      @(negedge clk);
      tests++;
      if (dut1.state_q !== StIdle || if1.csn !== 1'b1 || if1.oe !== 1'b0 ||
          if1.ack !== 1'b0 || if1.st !== 5'd0) begin
        fails++;
        $display("FAIL bad_state code=%0d got state=%0d csn=%b oe=%b ack=%b exp 0 1 0 0",
                 code, dut1.state_q, if1.csn, if1.oe, if1.ack);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    req   = 1'b0;
    test_reset();
    test_burst();
    test_req_drop();
    test_reset_mid();
    test_bad_state();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
